// File: rtl/falco_pkg.sv
// Falco shared types for the memory arbiter: requester IDs, arbiter FSM states and small helpers.
// Optional performance counters in falco_mem_arbiter are enabled by FALCO_ARB_PERF_CNT_EN.
package falco_pkg;

    localparam int XLEN_WIDTH = 32;

    typedef enum logic [1:0] {
        ARB_SRC_IFU = 2'd0,
        ARB_SRC_LD  = 2'd1,
        ARB_SRC_ST  = 2'd2
    } arb_src_e;

    typedef enum logic [1:0] {
        ARB_ST_ARB   = 2'd0,
        ARB_ST_DRAIN = 2'd1,
        ARB_ST_DONE  = 2'd2
    } arb_state_e;

    function automatic arb_src_e arb_next_src(input arb_src_e src);
        case (src)
            ARB_SRC_IFU: return ARB_SRC_LD;
            ARB_SRC_LD:  return ARB_SRC_ST;
            default:     return ARB_SRC_IFU;
        endcase
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        if (en && (v != 32'hFFFF_FFFF)) begin
            return v + 32'd1;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/falco_arb_id_fifo.sv
// In-order FIFO of requester IDs for outstanding memory transactions; pushes when full and
// pops when empty are ignored.
module falco_arb_id_fifo #(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  falco_pkg::arb_src_e  push_id_i,
    input  logic                 pop_i,
    output falco_pkg::arb_src_e  head_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [AW:0]          count_o
);
    import falco_pkg::*;

    arb_src_e        mem_q [DEPTH];
    logic [AW-1:0]   wr_q;
    logic [AW-1:0]   rd_q;
    logic [AW:0]     cnt_q;
    logic            push_ok_s;
    logic            pop_ok_s;

    assign full_o    = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o   = (cnt_q == {(AW+1){1'b0}});
    assign count_o   = cnt_q;
    assign head_o    = mem_q[rd_q];
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= {AW{1'b0}};
            rd_q  <= {AW{1'b0}};
            cnt_q <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= ARB_SRC_IFU;
            end
        end else begin
            if (push_ok_s) begin
                mem_q[wr_q] <= push_id_i;
                wr_q        <= wr_q + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_q <= rd_q + {{(AW-1){1'b0}}, 1'b1};
            end
            cnt_q <= cnt_q + {{AW{1'b0}}, push_ok_s} - {{AW{1'b0}}, pop_ok_s};
        end
    end

endmodule

// File: rtl/falco_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU, load and store, with in-order
// response routing and a fence drain sequencer. FALCO_ARB_PERF_CNT_EN adds performance counters.
module falco_mem_arbiter #(
    parameter int XLEN_WIDTH      = falco_pkg::XLEN_WIDTH,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ifu_req_valid,
    output logic                    ifu_req_ready,
    input  logic [XLEN_WIDTH-1:0]   ifu_req_addr,
    input  logic                    ld_req_valid,
    output logic                    ld_req_ready,
    input  logic [XLEN_WIDTH-1:0]   ld_req_addr,
    input  logic                    st_req_valid,
    output logic                    st_req_ready,
    input  logic [XLEN_WIDTH-1:0]   st_req_addr,
    input  logic [XLEN_WIDTH-1:0]   st_req_wdata,
    input  logic [XLEN_WIDTH/8-1:0] st_req_wstrb,
    output logic                    ifu_resp_valid,
    output logic [XLEN_WIDTH-1:0]   ifu_resp_data,
    output logic                    ld_resp_valid,
    output logic [XLEN_WIDTH-1:0]   ld_resp_data,
    output logic                    st_resp_valid,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_we,
    output logic [XLEN_WIDTH-1:0]   mem_req_addr,
    output logic [XLEN_WIDTH-1:0]   mem_req_wdata,
    output logic [XLEN_WIDTH/8-1:0] mem_req_wstrb,
    input  logic                    mem_resp_valid,
    input  logic [XLEN_WIDTH-1:0]   mem_resp_rdata,
    input  logic                    fence_req,
    output logic                    fence_done,
`ifdef FALCO_ARB_PERF_CNT_EN
    output logic [31:0]             perf_grant_ifu,
    output logic [31:0]             perf_grant_ld,
    output logic [31:0]             perf_grant_st,
    output logic [31:0]             perf_full_cycles,
`endif
    output logic                    err_unexp_resp
);
    import falco_pkg::*;

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_e              state_q, state_d;
    arb_src_e                rr_q, rr_d;
    arb_src_e                lock_src_q, lock_src_d;
    arb_src_e                gnt_src_s, cand_s, head_s;
    logic                    lock_q, lock_d;
    logic                    gnt_s, hs_s, pop_s;
    logic                    full_s, empty_s;
    logic [2:0]              valid_s;
    logic [CW-1:0]           count_s;
    logic                    ifu_rv_q, ld_rv_q, st_rv_q, err_q, done_q;
    logic [XLEN_WIDTH-1:0]   rdata_q;

    assign valid_s = {st_req_valid, ld_req_valid, ifu_req_valid};
    assign hs_s    = gnt_s & mem_req_ready;
    assign pop_s   = mem_resp_valid & ~empty_s;

    falco_arb_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_id_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (hs_s),
        .push_id_i (gnt_src_s),
        .pop_i     (pop_s),
        .head_o    (head_s),
        .full_o    (full_s),
        .empty_o   (empty_s),
        .count_o   (count_s)
    );

    // Grant selection: a stalled grant stays latched, otherwise first valid from the RR pointer
    always_comb begin
        gnt_s     = 1'b0;
        gnt_src_s = ARB_SRC_IFU;
        cand_s    = rr_q;
        if (!rst) begin
            gnt_s = 1'b0;
        end else if (lock_q) begin
            gnt_s     = valid_s[lock_src_q];
            gnt_src_s = lock_src_q;
        end else if ((state_q == ARB_ST_ARB) && !full_s) begin
            for (int i = 0; i < 3; i++) begin
                if (!gnt_s && valid_s[cand_s]) begin
                    gnt_s     = 1'b1;
                    gnt_src_s = cand_s;
                end
                cand_s = arb_next_src(cand_s);
            end
        end else begin
            gnt_s = 1'b0;
        end
    end

    // Memory request mux from the granted source
    always_comb begin
        mem_req_valid = gnt_s;
        mem_req_we    = 1'b0;
        mem_req_addr  = {XLEN_WIDTH{1'b0}};
        mem_req_wdata = {XLEN_WIDTH{1'b0}};
        mem_req_wstrb = {(XLEN_WIDTH/8){1'b0}};
        if (gnt_s) begin
            case (gnt_src_s)
                ARB_SRC_IFU: mem_req_addr = ifu_req_addr;
                ARB_SRC_LD:  mem_req_addr = ld_req_addr;
                ARB_SRC_ST: begin
                    mem_req_we    = 1'b1;
                    mem_req_addr  = st_req_addr;
                    mem_req_wdata = st_req_wdata;
                    mem_req_wstrb = st_req_wstrb;
                end
                default: mem_req_valid = 1'b0;
            endcase
        end else begin
            mem_req_valid = 1'b0;
        end
    end

    assign ifu_req_ready = hs_s & (gnt_src_s == ARB_SRC_IFU);
    assign ld_req_ready  = hs_s & (gnt_src_s == ARB_SRC_LD);
    assign st_req_ready  = hs_s & (gnt_src_s == ARB_SRC_ST);

    // Pointer, grant latch and fence sequencing; DRAIN is entered only once no grant is stalled
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        lock_d     = 1'b0;
        lock_src_d = lock_src_q;
        if (hs_s) begin
            rr_d = arb_next_src(gnt_src_s);
        end else if (gnt_s) begin
            lock_d     = 1'b1;
            lock_src_d = gnt_src_s;
        end else begin
            lock_d = 1'b0;
        end
        case (state_q)
            ARB_ST_ARB: begin
                if (fence_req && !(gnt_s && !mem_req_ready)) state_d = ARB_ST_DRAIN;
                else                                         state_d = ARB_ST_ARB;
            end
            ARB_ST_DRAIN: begin
                if (count_s == {CW{1'b0}}) state_d = ARB_ST_DONE;
                else                       state_d = ARB_ST_DRAIN;
            end
            ARB_ST_DONE: begin
                if (!fence_req) state_d = ARB_ST_ARB;
                else            state_d = ARB_ST_DONE;
            end
            default: state_d = ARB_ST_ARB;
        endcase
    end

    // FSM, arbitration state and registered responses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_ST_ARB;
            rr_q       <= ARB_SRC_IFU;
            lock_q     <= 1'b0;
            lock_src_q <= ARB_SRC_IFU;
            done_q     <= 1'b0;
            ifu_rv_q   <= 1'b0;
            ld_rv_q    <= 1'b0;
            st_rv_q    <= 1'b0;
            rdata_q    <= {XLEN_WIDTH{1'b0}};
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
            done_q     <= (state_d == ARB_ST_DONE);
            ifu_rv_q   <= pop_s & (head_s == ARB_SRC_IFU);
            ld_rv_q    <= pop_s & (head_s == ARB_SRC_LD);
            st_rv_q    <= pop_s & (head_s == ARB_SRC_ST);
            if (pop_s && (head_s != ARB_SRC_ST)) rdata_q <= mem_resp_rdata;
            else                                 rdata_q <= rdata_q;
            if (mem_resp_valid && empty_s) err_q <= 1'b1;
            else                           err_q <= err_q;
        end
    end

    assign ifu_resp_valid = ifu_rv_q;
    assign ld_resp_valid  = ld_rv_q;
    assign st_resp_valid  = st_rv_q;
    assign ifu_resp_data  = rdata_q;
    assign ld_resp_data   = rdata_q;
    assign fence_done     = done_q;
    assign err_unexp_resp = err_q;

`ifdef FALCO_ARB_PERF_CNT_EN
    logic [31:0] pg_ifu_q, pg_ld_q, pg_st_q, pfull_q;

    // Saturating grant and FIFO-full pressure counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pg_ifu_q <= 32'd0;
            pg_ld_q  <= 32'd0;
            pg_st_q  <= 32'd0;
            pfull_q  <= 32'd0;
        end else begin
            pg_ifu_q <= sat_inc32(pg_ifu_q, ifu_req_ready);
            pg_ld_q  <= sat_inc32(pg_ld_q, ld_req_ready);
            pg_st_q  <= sat_inc32(pg_st_q, st_req_ready);
            pfull_q  <= sat_inc32(pfull_q, full_s & (|valid_s));
        end
    end

    assign perf_grant_ifu   = pg_ifu_q;
    assign perf_grant_ld    = pg_ld_q;
    assign perf_grant_st    = pg_st_q;
    assign perf_full_cycles = pfull_q;
`endif

endmodule

// File: tb/tb_falco_mem_arbiter.sv
// Self-checking bench for falco_mem_arbiter: cycle table of directed scenarios, hand-written
// stall/error/reset sequences, then random traffic against a queue-based reference model.
module tb_falco_mem_arbiter;

    logic        clk, rst;
    logic        ifu_req_valid, ifu_req_ready, ld_req_valid, ld_req_ready, st_req_valid, st_req_ready;
    logic [31:0] ifu_req_addr, ld_req_addr, st_req_addr, st_req_wdata;
    logic [3:0]  st_req_wstrb, mem_req_wstrb;
    logic        ifu_resp_valid, ld_resp_valid, st_resp_valid;
    logic [31:0] ifu_resp_data, ld_resp_data;
    logic        mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
    logic        fence_req, fence_done, err_unexp_resp;

    falco_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_addr(ld_req_addr),
        .st_req_valid(st_req_valid), .st_req_ready(st_req_ready), .st_req_addr(st_req_addr),
        .st_req_wdata(st_req_wdata), .st_req_wstrb(st_req_wstrb),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
        .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data), .st_resp_valid(st_resp_valid),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .fence_req(fence_req), .fence_done(fence_done), .err_unexp_resp(err_unexp_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [141:0] outs_w = {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
                           st_req_ready, ld_req_ready, ifu_req_ready,
                           st_resp_valid, ld_resp_valid, ifu_resp_valid,
                           ifu_resp_data, ld_resp_data, fence_done, err_unexp_resp};
    wire [2:0] rdy_w = {st_req_ready, ld_req_ready, ifu_req_ready};
    wire [2:0] rsp_w = {st_resp_valid, ld_resp_valid, ifu_resp_valid};

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [2:0] v, input logic r, input logic rv, input logic [7:0] rd,
                         input logic f);
        @(negedge clk);
        {st_req_valid, ld_req_valid, ifu_req_valid} = v;
        mem_req_ready  = r;
        mem_resp_valid = rv;
        mem_resp_rdata = {24'd0, rd};
        fence_req      = f;
        #1;
    endtask

    typedef struct {
        logic [2:0] v;    logic rdy; logic rv; logic [7:0] rd; logic f;
        logic       mv;   logic [2:0] g; logic [2:0] rsp; logic [7:0] dat; logic done;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [2:0] v, input logic rdy, input logic rv, input logic [7:0] rd,
                       input logic f, input logic mv, input logic [2:0] g, input logic [2:0] rsp,
                       input logic [7:0] dat, input logic done);
        vec_t e;
        e.v = v; e.rdy = rdy; e.rv = rv; e.rd = rd; e.f = f;
        e.mv = mv; e.g = g; e.rsp = rsp; e.dat = dat; e.done = done;
        tbl.push_back(e);
    endtask

    // reference model state for the random phase
    int          out_q[$];
    int          due_q[$];
    int          rr, stalled, g, last_due, due, s;
    logic        pend[3];
    logic [31:0] paddr[3];
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  exp_rsp, nrsp, exp_rdy;
    logic [31:0] exp_data;
    logic        exp_err, r_rdy, r_rv;
    logic [31:0] r_rd;

    initial begin
        rst = 1'b0;
        {ifu_req_valid, ld_req_valid, st_req_valid, mem_req_ready, mem_resp_valid, fence_req} = 6'd0;
        ifu_req_addr = 32'h100; ld_req_addr = 32'h200; st_req_addr = 32'h300;
        st_req_wdata = 32'hAAAA_5555; st_req_wstrb = 4'hF; mem_resp_rdata = 32'd0;
        @(negedge clk); @(negedge clk);
        chk("reset_outputs", {18'd0, outs_w}, 160'd0);
        rst = 1'b1;

        // round robin with latency-2 responses
        add(3'b111,1'b1,1'b0,8'h00,1'b0, 1'b1,3'b001,3'b000,8'h00,1'b0);
        add(3'b111,1'b1,1'b0,8'h00,1'b0, 1'b1,3'b010,3'b000,8'h00,1'b0);
        add(3'b111,1'b1,1'b1,8'h11,1'b0, 1'b1,3'b100,3'b000,8'h00,1'b0);
        add(3'b111,1'b1,1'b1,8'h22,1'b0, 1'b1,3'b001,3'b001,8'h11,1'b0);
        add(3'b000,1'b1,1'b1,8'h33,1'b0, 1'b0,3'b000,3'b010,8'h22,1'b0);
        add(3'b000,1'b1,1'b1,8'h44,1'b0, 1'b0,3'b000,3'b100,8'h00,1'b0);
        add(3'b000,1'b1,1'b0,8'h00,1'b0, 1'b0,3'b000,3'b001,8'h44,1'b0);
        // load held until the ID FIFO fills; a same-cycle pop does not bypass
        for (int k = 0; k < 4; k++) add(3'b010,1'b1,1'b0,8'h00,1'b0, 1'b1,3'b010,3'b000,8'h00,1'b0);
        add(3'b010,1'b1,1'b0,8'h00,1'b0, 1'b0,3'b000,3'b000,8'h00,1'b0);
        add(3'b010,1'b1,1'b1,8'h55,1'b0, 1'b0,3'b000,3'b000,8'h00,1'b0);
        add(3'b010,1'b1,1'b0,8'h00,1'b0, 1'b1,3'b010,3'b010,8'h55,1'b0);
        add(3'b000,1'b1,1'b1,8'h66,1'b0, 1'b0,3'b000,3'b000,8'h00,1'b0);
        add(3'b000,1'b1,1'b1,8'h77,1'b0, 1'b0,3'b000,3'b010,8'h66,1'b0);
        add(3'b000,1'b1,1'b1,8'h88,1'b0, 1'b0,3'b000,3'b010,8'h77,1'b0);
        add(3'b000,1'b1,1'b1,8'h99,1'b0, 1'b0,3'b000,3'b010,8'h88,1'b0);
        add(3'b000,1'b1,1'b0,8'h00,1'b0, 1'b0,3'b000,3'b010,8'h99,1'b0);
        // fence with two outstanding fetches
        add(3'b001,1'b1,1'b0,8'h00,1'b0, 1'b1,3'b001,3'b000,8'h00,1'b0);
        add(3'b001,1'b1,1'b0,8'h00,1'b0, 1'b1,3'b001,3'b000,8'h00,1'b0);
        add(3'b000,1'b1,1'b0,8'h00,1'b1, 1'b0,3'b000,3'b000,8'h00,1'b0);
        add(3'b111,1'b1,1'b0,8'h00,1'b1, 1'b0,3'b000,3'b000,8'h00,1'b0);
        add(3'b111,1'b1,1'b1,8'hA1,1'b1, 1'b0,3'b000,3'b000,8'h00,1'b0);
        add(3'b111,1'b1,1'b1,8'hB2,1'b1, 1'b0,3'b000,3'b001,8'hA1,1'b0);
        add(3'b111,1'b1,1'b0,8'h00,1'b1, 1'b0,3'b000,3'b001,8'hB2,1'b0);
        add(3'b111,1'b1,1'b0,8'h00,1'b1, 1'b0,3'b000,3'b000,8'h00,1'b1);
        add(3'b111,1'b1,1'b0,8'h00,1'b0, 1'b0,3'b000,3'b000,8'h00,1'b1);
        add(3'b111,1'b1,1'b0,8'h00,1'b0, 1'b1,3'b010,3'b000,8'h00,1'b0);
        add(3'b000,1'b1,1'b1,8'hC3,1'b0, 1'b0,3'b000,3'b000,8'h00,1'b0);
        add(3'b000,1'b1,1'b0,8'h00,1'b0, 1'b0,3'b000,3'b010,8'hC3,1'b0);
        // fence with nothing outstanding
        add(3'b000,1'b1,1'b0,8'h00,1'b1, 1'b0,3'b000,3'b000,8'h00,1'b0);
        add(3'b000,1'b1,1'b0,8'h00,1'b1, 1'b0,3'b000,3'b000,8'h00,1'b0);
        add(3'b000,1'b1,1'b0,8'h00,1'b1, 1'b0,3'b000,3'b000,8'h00,1'b1);
        add(3'b000,1'b1,1'b0,8'h00,1'b0, 1'b0,3'b000,3'b000,8'h00,1'b1);
        add(3'b000,1'b1,1'b0,8'h00,1'b0, 1'b0,3'b000,3'b000,8'h00,1'b0);

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].v, tbl[k].rdy, tbl[k].rv, tbl[k].rd, tbl[k].f);
            chk($sformatf("row%0d ctl", k), {mem_req_valid, rdy_w, rsp_w, fence_done},
                {tbl[k].mv, tbl[k].g, tbl[k].rsp, tbl[k].done});
            if (tbl[k].rsp[0]) chk($sformatf("row%0d ifu_data", k), ifu_resp_data, {24'd0, tbl[k].dat});
            if (tbl[k].rsp[1]) chk($sformatf("row%0d ld_data", k), ld_resp_data, {24'd0, tbl[k].dat});
        end

        // store stalled by the memory for three cycles, pointer at ST
        for (int k = 0; k < 3; k++) begin
            drive(3'b111, 1'b0, 1'b0, 8'h00, 1'b0);
            chk($sformatf("stall%0d", k), {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
                mem_req_wstrb, rdy_w}, {1'b1, 1'b1, 32'h300, 32'hAAAA_5555, 4'hF, 3'b000});
        end
        drive(3'b111, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("stall_release", {mem_req_valid, mem_req_addr, rdy_w}, {1'b1, 32'h300, 3'b100});
        drive(3'b011, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("after_stall_grant", {mem_req_addr, rdy_w}, {32'h100, 3'b001});
        drive(3'b000, 1'b1, 1'b1, 8'h00, 1'b0);
        drive(3'b000, 1'b1, 1'b1, 8'hDE, 1'b0);
        chk("st_ack", rsp_w, 3'b100);
        drive(3'b000, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("ifu_after_stall", {rsp_w, ifu_resp_data}, {3'b001, 32'h0000_00DE});

        // response with nothing outstanding
        drive(3'b000, 1'b1, 1'b1, 8'h77, 1'b0);
        chk("pre_unexp_err", err_unexp_resp, 1'b0);
        drive(3'b000, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("unexp_resp", {rsp_w, err_unexp_resp}, {3'b000, 1'b1});
        drive(3'b000, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("err_sticky", err_unexp_resp, 1'b1);

        // reset with three requests in flight
        for (int k = 0; k < 3; k++) drive(3'b111, 1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        #1;
        chk("rst_async_outs", {18'd0, outs_w}, 160'd0);
        @(negedge clk); #1;
        chk("rst_held_outs", {18'd0, outs_w}, 160'd0);
        @(negedge clk);
        rst = 1'b1;
        {st_req_valid, ld_req_valid, ifu_req_valid, mem_resp_valid} = 4'd0;
        #1;
        chk("post_rst_err", err_unexp_resp, 1'b0);
        drive(3'b000, 1'b1, 1'b1, 8'h12, 1'b0);
        drive(3'b000, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("late_resp_unexp", {rsp_w, err_unexp_resp}, {3'b000, 1'b1});

        // random traffic against the reference model
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        rr = 0; stalled = -1; last_due = -1;
        exp_rsp = 3'b000; exp_data = 32'd0; exp_err = 1'b0;
        for (int k = 0; k < 3; k++) pend[k] = 1'b0;
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (!pend[k] && (c < 680) && ($urandom_range(1, 0) == 1)) begin
                    pend[k] = 1'b1;
                    paddr[k] = $urandom();
                    if (k == 2) begin
                        pwdata = $urandom();
                        pstrb  = 4'($urandom_range(15, 0));
                    end
                end
            end
            r_rdy = ($urandom_range(3, 0) != 0);
            r_rv  = (due_q.size() > 0) && (due_q[0] <= c);
            if (r_rv) void'(due_q.pop_front());
            r_rd  = $urandom();
            {ifu_req_valid, ld_req_valid, st_req_valid} = {pend[0], pend[1], pend[2]};
            ifu_req_addr = paddr[0]; ld_req_addr = paddr[1]; st_req_addr = paddr[2];
            st_req_wdata = pwdata; st_req_wstrb = pstrb;
            mem_req_ready = r_rdy; mem_resp_valid = r_rv; mem_resp_rdata = r_rd; fence_req = 1'b0;

            g = -1;
            if (stalled >= 0) g = stalled;
            else if (out_q.size() < 4)
                for (int i = 0; i < 3; i++) if (g < 0 && pend[(rr + i) % 3]) g = (rr + i) % 3;
            exp_rdy = 3'b000;
            if (g >= 0 && r_rdy) exp_rdy[g] = 1'b1;
            #1;
            chk($sformatf("rand%0d ctl", c), {mem_req_valid, rdy_w, rsp_w, fence_done, err_unexp_resp},
                {(g >= 0), exp_rdy, exp_rsp, 1'b0, exp_err});
            if (g >= 0)
                chk($sformatf("rand%0d req", c), {mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb},
                    {(g == 2), paddr[g], (g == 2) ? pwdata : 32'd0, (g == 2) ? pstrb : 4'd0});
            if (exp_rsp[0]) chk($sformatf("rand%0d ifu_data", c), ifu_resp_data, exp_data);
            if (exp_rsp[1]) chk($sformatf("rand%0d ld_data", c), ld_resp_data, exp_data);

            nrsp = 3'b000;
            if (r_rv) begin
                if (out_q.size() == 0) exp_err = 1'b1;
                else begin
                    s = out_q.pop_front();
                    nrsp[s] = 1'b1;
                    exp_data = r_rd;
                end
            end
            if (g >= 0) begin
                if (r_rdy) begin
                    out_q.push_back(g);
                    rr = (g + 1) % 3;
                    stalled = -1;
                    pend[g] = 1'b0;
                    due = c + $urandom_range(3, 1);
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    due_q.push_back(due);
                end else begin
                    stalled = g;
                end
            end
            exp_rsp = nrsp;
        end

        @(negedge clk);
        {ifu_req_valid, ld_req_valid, st_req_valid, mem_resp_valid} = 4'd0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
